// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the data-RAM arbiter: FSM state encoding and access modes.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b01;
    localparam logic [1:0] MODE_WORD = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

endpackage

// File: rtl/ram_align_chk.sv
// Combinational alignment check: flags reserved modes and halfword/word accesses that
// are not naturally aligned. One instance per requester port.
module ram_align_chk
    import ram_arb_pkg::*;
(
    input  logic [1:0] mode_i,
    input  logic [1:0] addr_lo_i,
    output logic       err_o
);

    always_comb begin
        err_o = 1'b0;
        case (mode_i)
            MODE_BYTE: err_o = 1'b0;
            MODE_HALF: err_o = addr_lo_i[0];
            MODE_WORD: err_o = (addr_lo_i != 2'b00);
            default:   err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter and three-cycle access sequencer for the shared data RAM.
// Define RAM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [1:0]            mode0,
    input  logic [1:0]            mode1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [31:0]           wdata0,
    input  logic [31:0]           wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [31:0]           rdata0,
    output logic [31:0]           rdata1,
    output logic                  err0,
    output logic                  err1,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_din,
    output logic [1:0]            ram_mode,
    output logic                  ram_str,
    output logic                  ram_sel,
    input  logic [31:0]           ram_dout
);

    state_t                  state_q, state_d;
    logic                    own_q, we_q, err_q;
    logic [1:0]              mode_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             wdata_q;
    logic                    rvalid0_q, rvalid1_q, err0_q, err1_q;
    logic [31:0]             rdata0_q, rdata1_q;
    logic                    chk_err0, chk_err1;
    logic                    win;   // 0 = port 0 wins this IDLE sample
    logic                    any_req;
    logic [31:0]             rd_val;

    ram_align_chk u_chk0 (.mode_i(mode0), .addr_lo_i(addr0[1:0]), .err_o(chk_err0));
    ram_align_chk u_chk1 (.mode_i(mode1), .addr_lo_i(addr1[1:0]), .err_o(chk_err1));

    assign any_req = req0 | req1;

`ifdef RAM_ARB_RR_EN
    logic last_q;   // port served most recently; reset value lets port 0 win first

    always_comb win = (req0 && req1) ? ~last_q : ~req0;

    always_ff @(posedge clk) begin
        if (clr)
            last_q <= 1'b1;
        else if (state_q == IDLE && any_req)
            last_q <= win;
    end
`else
    always_comb win = ~req0;
`endif

    always_ff @(posedge clk) begin
        if (clr)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Request latch: only meaningful while ACCESS/RESP, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && any_req) begin
            own_q   <= win;
            we_q    <= win ? we1    : we0;
            mode_q  <= win ? mode1  : mode0;
            addr_q  <= win ? addr1  : addr0;
            wdata_q <= win ? wdata1 : wdata0;
            err_q   <= win ? chk_err1 : chk_err0;
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        ram_addr = '0;
        ram_mode = 2'b00;
        ram_din  = 32'd0;
        ram_sel  = 1'b0;
        ram_str  = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req)
                    state_d = ACCESS;
            end
            ACCESS: begin
                state_d  = RESP;
                gnt0     = ~own_q;
                gnt1     = own_q;
                ram_addr = addr_q;
                ram_mode = mode_q;
                ram_din  = wdata_q;
                ram_sel  = ~err_q;
                ram_str  = we_q & ~err_q;
            end
            RESP: begin
                state_d  = IDLE;
                ram_addr = addr_q;
                ram_mode = mode_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // Stores and faulted accesses return zero regardless of what the RAM drives.
    assign rd_val = (we_q | err_q) ? 32'd0 : ram_dout;

    always_ff @(posedge clk) begin
        if (clr) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= 32'd0;
            rdata1_q  <= 32'd0;
        end else begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            if (state_q == RESP) begin
                if (!own_q) begin
                    rvalid0_q <= 1'b1;
                    err0_q    <= err_q;
                    rdata0_q  <= rd_val;
                end else begin
                    rvalid1_q <= 1'b1;
                    err1_q    <= err_q;
                    rdata1_q  <= rd_val;
                end
            end
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign err0    = err0_q;
    assign err1    = err1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule
